// File: rtl/result_stream_reader.sv
// result_stream_reader: buffers up to DEPTH datapath results and streams them
// out in address order over a valid/ready interface once done_in arrives.
module result_stream_reader #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              done_in,
    input  logic [ADDR_W:0]   count_in,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              rd_done,
    output logic              wr_err
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] PREFETCH = 2'd1;
    localparam logic [1:0] STREAM   = 2'd2;
    localparam logic [1:0] DONE     = 2'd3;
    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] TWO  = (ADDR_W+1)'(2);

    logic [1:0]        state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   n;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_nx;
    logic [ADDR_W:0]   idx_w;
    logic [ADDR_W:0]   n_sat;
    logic              last_xfer;

    assign busy      = state != IDLE;
    assign rd_done   = state == DONE;
    assign idx_w     = {1'b0, idx};
    assign idx_nx    = idx + ADDR_W'(1);
    assign n_sat     = (count_in > FULL) ? FULL : count_in;
    assign last_xfer = idx_w + ONE == n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            n         <= '0;
            idx       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            wr_err    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            // writes are only legal while idle; anything else is dropped and flagged
            if (we && state != IDLE) wr_err <= 1'b1;
            case (state)
                IDLE: begin
                    if (we) mem[wr_addr] <= wr_data;
                    if (done_in) begin
                        n      <= n_sat;
                        idx    <= '0;
                        wr_err <= 1'b0;
                        state  <= (n_sat == '0) ? DONE : PREFETCH;
                    end
                end
                PREFETCH: begin
                    out_data  <= mem[0];
                    out_valid <= 1'b1;
                    out_last  <= n == ONE;
                    state     <= STREAM;
                end
                STREAM: begin
                    if (out_valid && out_ready) begin
                        if (last_xfer) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            state     <= DONE;
                        end else begin
                            idx      <= idx_nx;
                            out_data <= mem[idx_nx];
                            out_last <= idx_w + TWO == n;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_result_stream_reader.sv
// tb_result_stream_reader: table-driven and randomized checks of result_stream_reader
// against a queue-based model of the buffer and expected stream.
module tb_result_stream_reader;
    logic        clk;
    logic        rst;
    logic        we;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic        done_in;
    logic [3:0]  count_in;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        rd_done;
    logic        wr_err;

    int checks;
    int failures;
    logic [31:0] mdl [8];
    int pat [7] = '{1, 0, 0, 1, 0, 1, 1};

    typedef struct {
        string name;
        int    pre;
        int    cnt;
        int    mode;
        bit    inj;
        int    exp_n;
    } vec_t;

    vec_t vecs [7];

    result_stream_reader dut (
        .clk(clk), .rst(rst), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .done_in(done_in), .count_in(count_in), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .busy(busy), .rd_done(rd_done), .wr_err(wr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        we = 1'b1;
        wr_addr = 3'(a);
        wr_data = d;
        step();
        we = 1'b0;
        mdl[a] = d;
    endtask

    // mode 0: ready high, 1: random ready, 2: fixed backpressure pattern
    task automatic stream(input int cnt, input int mode, input bit inj, output int xfers);
        logic [31:0] exp_q [$];
        int n;
        int cyc;
        bit pv;
        bit pr;
        logic [31:0] pd;
        n = cnt > 8 ? 8 : cnt;
        for (int i = 0; i < n; i++) exp_q.push_back(mdl[i]);
        xfers = 0;
        done_in = 1'b1;
        count_in = 4'(cnt);
        step();
        done_in = 1'b0;
        we = 1'b0;
        chk("busy_after_done", busy, 1);
        chk("wr_err_cleared", wr_err, 0);
        chk("valid_low_first", out_valid, 0);
        if (n == 0) begin
            chk("rd_done_zero_count", rd_done, 1);
        end else begin
            chk("rd_done_prefetch", rd_done, 0);
            step();
            chk("valid_latency", out_valid, 1);
            pv = 1'b0;
            pr = 1'b0;
            pd = '0;
            cyc = 0;
            while (exp_q.size() > 0 && cyc < 200) begin
                out_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) :
                            (cyc < 7 ? 1'(pat[cyc]) : 1'b1);
                we = inj && cyc == 1;
                wr_addr = 3'd2;
                wr_data = 32'hDEAD;
                chk("valid_held", out_valid, 1);
                chk("no_early_rd_done", rd_done, 0);
                if (pv && !pr) chk("data_stable", out_data, pd);
                if (out_ready) begin
                    xfers++;
                    chk("stream_data", out_data, exp_q.pop_front());
                    chk("stream_last", out_last, exp_q.size() == 0);
                end
                pv = 1'b1;
                pr = out_ready;
                pd = out_data;
                step();
                cyc++;
            end
            we = 1'b0;
            chk("stream_timeout", cyc < 200, 1);
            chk("valid_after_last", out_valid, 0);
            chk("rd_done_pulse", rd_done, 1);
        end
        step();
        chk("rd_done_single", rd_done, 0);
        chk("busy_idle", busy, 0);
        if (inj) chk("wr_err_sticky", wr_err, 1);
    endtask

    initial begin
        int x;
        checks = 0;
        failures = 0;
        rst = 1'b0;
        we = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        done_in = 1'b0;
        count_in = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) mdl[i] = '0;
        vecs[0] = '{"basic",        0, 4,  0, 1'b0, 4};
        vecs[1] = '{"backpressure", 0, 4,  2, 1'b0, 4};
        vecs[2] = '{"count_zero",   0, 0,  0, 1'b0, 0};
        vecs[3] = '{"write_busy",   0, 4,  0, 1'b1, 4};
        vecs[4] = '{"restream",     0, 4,  0, 1'b0, 4};
        vecs[5] = '{"saturate",     1, 9,  0, 1'b0, 8};
        vecs[6] = '{"sat_random",   0, 12, 1, 1'b0, 8};
        step();
        step();
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rd_done", rd_done, 0);
        chk("rst_wr_err", wr_err, 0);
        rst = 1'b1;
        step();
        wr(0, 32'h11);
        wr(1, 32'h22);
        wr(2, 32'h33);
        wr(3, 32'h44);
        for (int v = 0; v < 7; v++) begin
            if (vecs[v].pre == 1) for (int i = 0; i < 8; i++) wr(i, 32'(i + 1));
            stream(vecs[v].cnt, vecs[v].mode, vecs[v].inj, x);
            chk(vecs[v].name, x, vecs[v].exp_n);
        end
        we = 1'b1;
        wr_addr = 3'd0;
        wr_data = 32'hAB;
        mdl[0] = 32'hAB;
        stream(1, 0, 1'b0, x);
        chk("same_cycle_wr_done", x, 1);
        for (int r = 0; r < 15; r++) begin
            int nw;
            int c;
            nw = $urandom_range(0, 5);
            for (int k = 0; k < nw; k++) wr($urandom_range(0, 7), $urandom);
            c = $urandom_range(0, 10);
            stream(c, 1, 1'b0, x);
            chk("random_xfers", x, c > 8 ? 8 : c);
        end
        for (int i = 0; i < 4; i++) wr(i, 32'h100 + 32'(i));
        done_in = 1'b1;
        count_in = 4'd4;
        step();
        done_in = 1'b0;
        step();
        out_ready = 1'b1;
        step();
        step();
        #1 rst = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_rd_done", rd_done, 0);
        chk("async_rst_data", out_data, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_no_rd_done", rd_done, 0);
        end
        rst = 1'b1;
        for (int i = 0; i < 8; i++) mdl[i] = '0;
        step();
        chk("post_rst_idle", busy, 0);
        stream(8, 0, 1'b0, x);
        chk("post_rst_zero_stream", x, 8);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
